// File: rtl/multi_clk_divider.sv
// multi_clk_divider: N-channel programmable clock divider.
// Each channel divides clk by (period+1) with a programmable high time.
// New settings arrive over a valid/ready port, wait in a shadow register
// and are applied only at a period boundary, so clk_out never shows a runt pulse.
// clk_out and tick are flops loaded from next-state values (no combinational
// path to the pins).

module multi_clk_divider #(
    parameter int NCH        = 4,
    parameter int WIDTH      = 26,
    parameter int DEF_PERIOD = 59999999,
    parameter int DEF_HIGH   = 30000000,
    localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CW-1:0]    cfg_chan,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   busy
);

    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEF_PERIOD);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEF_HIGH);

    logic [NCH-1:0] pend_v;

    // A channel can take a new config only once its previous one has been
    // applied; channel numbers beyond NCH match nothing and are always ready.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_chan == CW'(i)) begin
                cfg_ready = !pend_v[i];
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] p_act;
        logic [WIDTH-1:0] h_act;
        logic [WIDTH-1:0] p_pend;
        logic [WIDTH-1:0] h_pend;
        logic             pend;
        logic             en_q;
        logic             clk_q;
        logic             tick_q;

        logic             accept;
        logic             apply;
        logic [WIDTH-1:0] cnt_n;
        logic [WIDTH-1:0] p_n;
        logic [WIDTH-1:0] h_n;

        // Next-state values; tick_q marks that the current cycle is the wrap
        // cycle, so it doubles as the period boundary for applying a shadow config.
        always_comb begin
            accept = cfg_valid && !pend && (cfg_chan == CW'(i));
            apply  = pend && (!en[i] || tick_q);
            p_n    = apply ? p_pend : p_act;
            h_n    = apply ? h_pend : h_act;
            if (!en[i] || !en_q || tick_q) begin
                cnt_n = '0;
            end else begin
                cnt_n = cnt + WIDTH'(1);
            end
        end

        // Channel state: counter, active/shadow settings and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt    <= '0;
                p_act  <= DEF_P;
                h_act  <= DEF_H;
                p_pend <= '0;
                h_pend <= '0;
                pend   <= 1'b0;
                en_q   <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt    <= cnt_n;
                p_act  <= p_n;
                h_act  <= h_n;
                en_q   <= en[i];
                clk_q  <= en[i] && (cnt_n < h_n);
                tick_q <= en[i] && (cnt_n == p_n);
                if (accept) begin
                    p_pend <= cfg_period;
                    h_pend <= cfg_high;
                    pend   <= 1'b1;
                end else if (apply) begin
                    pend   <= 1'b0;
                end
            end
        end

        assign pend_v[i]  = pend;
        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign busy[i]    = pend;
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed testbench for multi_clk_divider (NCH=2, WIDTH=8, P=9, H=5 defaults).
// A stimulus process drives one cycle at a time and pushes the hand-derived
// expected outputs for that cycle; a monitor pops and compares at negedge.

module tb_multi_clk_divider;

    localparam int NCH   = 2;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_chan;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_high;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   busy;

    typedef struct {
        int         k;
        logic [1:0] clk_out;
        logic [1:0] tick;
        logic [1:0] busy;
        logic       ready;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    multi_clk_divider #(
        .NCH(NCH), .WIDTH(WIDTH), .DEF_PERIOD(9), .DEF_HIGH(5)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
        .cfg_period(cfg_period), .cfg_high(cfg_high),
        .clk_out(clk_out), .tick(tick), .busy(busy)
    );

    always #5 clk = ~clk;

    // {clk_out, tick} at phase ph of a period of per cycles with hi high cycles
    function automatic logic [1:0] pat(int ph, int per, int hi);
        int r;
        r = ph % per;
        return {(r < hi) ? 1'b1 : 1'b0, (r == per - 1) ? 1'b1 : 1'b0};
    endfunction

    function automatic logic [1:0] exp_ch0(int k);
        if (k < 0)    return 2'b00;
        if (k <= 29)  return pat(k, 10, 5);
        if (k <= 45)  return pat(k - 30, 4, 1);
        if (k <= 61)  return pat(k - 46, 2, 1);
        if (k <= 71)  return {1'b0, (k == 71) ? 1'b1 : 1'b0};
        if (k <= 81)  return {1'b1, (k == 81) ? 1'b1 : 1'b0};
        if (k <= 86)  return 2'b11;
        if (k <= 90)  return 2'b00;
        if (k <= 100) return pat(k - 91, 5, 2);
        if (k == 101) return 2'b00;
        return pat(k - 102, 10, 5);
    endfunction

    function automatic logic [1:0] exp_ch1(int k);
        if (k < 0)    return 2'b00;
        if (k <= 49)  return pat(k, 10, 5);
        if (k <= 54)  return pat(k - 50, 5, 2);
        if (k <= 93)  return pat(k - 55, 3, 1);
        if (k <= 100) return pat(k - 94, 10, 3);
        if (k == 101) return 2'b00;
        return pat(k - 102, 10, 5);
    endfunction

    function automatic logic [1:0] exp_busy(int k);
        logic b0, b1;
        b0 = (k >= 24 && k <= 29) || (k >= 44 && k <= 45) || (k == 61) ||
             (k >= 66 && k <= 71) || (k >= 76 && k <= 81) || (k == 88);
        b1 = (k >= 43 && k <= 49) || (k >= 51 && k <= 54) || (k == 93) ||
             (k >= 99 && k <= 100);
        return {b1, b0};
    endfunction

    task automatic setCfg(input logic v, input logic ch, input int p, input int h);
        cfg_valid  = v;
        cfg_chan   = ch;
        cfg_period = WIDTH'(p);
        cfg_high   = WIDTH'(h);
    endtask

    // Drive the inputs of cycle k and queue the outputs expected in that cycle.
    task automatic applyStimulus(input int k);
        exp_t       e;
        logic [1:0] c0, c1, b;
        @(posedge clk);
        #1;
        rst = (k == -3 || k == -2 || k == 100);
        en  = (k <= -2) ? 2'b00 : 2'b11;
        if (k >= 86 && k <= 89) en[0] = 1'b0;
        setCfg(1'b0, 1'b0, 0, 0);
        case (k)
            23: setCfg(1'b1, 1'b0, 3, 1);
            42: setCfg(1'b1, 1'b1, 4, 2);
            43: setCfg(1'b1, 1'b0, 1, 1);
            60: setCfg(1'b1, 1'b0, 9, 0);
            65: setCfg(1'b1, 1'b0, 9, 12);
            75: setCfg(1'b1, 1'b0, 0, 1);
            87: setCfg(1'b1, 1'b0, 4, 2);
            92: setCfg(1'b1, 1'b1, 9, 3);
            98: setCfg(1'b1, 1'b1, 1, 1);
            default: ;
        endcase
        if (k >= 44 && k <= 50) setCfg(1'b1, 1'b1, 2, 1);
        c0 = exp_ch0(k);
        c1 = exp_ch1(k);
        b  = exp_busy(k);
        e.k       = k;
        e.clk_out = {c1[1], c0[1]};
        e.tick    = {c1[0], c0[0]};
        e.busy    = b;
        e.ready   = cfg_chan ? !b[1] : !b[0];
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int k,
                               input logic [1:0] act, input logic [1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, k, act, want);
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput("clk_out",   mon_e.k, clk_out, mon_e.clk_out);
            checkOutput("tick",      mon_e.k, tick, mon_e.tick);
            checkOutput("busy",      mon_e.k, busy, mon_e.busy);
            checkOutput("cfg_ready", mon_e.k, {1'b0, cfg_ready}, {1'b0, mon_e.ready});
        end
    end

    initial begin
        rst = 1'b1;
        en  = 2'b00;
        setCfg(1'b0, 1'b0, 0, 0);
        $display("[TB] start: defaults, reload, back-pressure, duty extremes, disable, reset");
        for (int k = -3; k <= 113; k++) begin
            applyStimulus(k);
        end
        repeat (2) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
